// File: rtl/shiftreg_loader_if.sv
// Bundle between the shift-register sequencer and the loader: load request, parallel words,
// serial chain pins, latch strobes and status. The master is the requester/chain side.
interface shiftreg_loader_if #(
  parameter int SIZESRSTAT = 88,
  parameter int SIZESRDYN  = 16
);
  logic                  START;
  logic                  SEL_STAT;
  logic [SIZESRDYN-1:0]  DYN_WORD;
  logic [SIZESRSTAT-1:0] STAT_WORD;
  logic                  SDIN;
  logic                  SDATA;
  logic                  SCLK;
  logic                  DYNLATCH;
  logic                  STATLATCH;
  logic                  BUSY;
  logic                  DONE;
  logic [SIZESRSTAT-1:0] RB_DATA;

  modport master (
    output START, SEL_STAT, DYN_WORD, STAT_WORD, SDIN,
    input  SDATA, SCLK, DYNLATCH, STATLATCH, BUSY, DONE, RB_DATA
  );

  modport slave (
    input  START, SEL_STAT, DYN_WORD, STAT_WORD, SDIN,
    output SDATA, SCLK, DYNLATCH, STATLATCH, BUSY, DONE, RB_DATA
  );
endinterface

// File: rtl/shiftreg_loader.sv
// Serializes a captured dynamic/static word MSB-first into the external chain, then strobes its latch.
// Optional chain readback through SDIN is built only when SHIFTREG_READBACK_EN is defined.
module shiftreg_loader #(
  parameter int SIZESRSTAT = 88,
  parameter int SIZESRDYN  = 16,
  parameter int CLKDIV     = 2
) (
  input  logic            CLK,
  input  logic            RST,
  shiftreg_loader_if.slave bus
);

  localparam int DIV_W = $clog2(2 * CLKDIV + 1);
  localparam int BIT_W = $clog2(SIZESRSTAT + 1);
  localparam logic [DIV_W-1:0] DIV_ONE      = DIV_W'(1);
  localparam logic [DIV_W-1:0] DIV_HALF     = DIV_W'(CLKDIV);
  localparam logic [DIV_W-1:0] DIV_LOW_LAST = DIV_W'(CLKDIV - 1);
  localparam logic [DIV_W-1:0] DIV_LAST     = DIV_W'(2 * CLKDIV - 1);
  localparam logic [BIT_W-1:0] BIT_ONE      = BIT_W'(1);
  localparam logic [BIT_W-1:0] BIT_STAT_TOP = BIT_W'(SIZESRSTAT - 1);
  localparam logic [BIT_W-1:0] BIT_DYN_TOP  = BIT_W'(SIZESRDYN - 1);

  typedef enum logic [1:0] {IDLE, SHIFT, LATCH, FIN} state_t;

  state_t                state_q, state_d;
  logic [DIV_W-1:0]      div_q, div_d;
  logic [BIT_W-1:0]      bit_q, bit_d;
  logic                  sel_q, sel_d;
  logic [SIZESRSTAT-1:0] sh_q, sh_d;
  logic                  sdata_q, sdata_d;
  logic                  sclk_q, sclk_d;
  logic                  dynl_q, dynl_d;
  logic                  statl_q, statl_d;
  logic                  busy_q, busy_d;
  logic                  done_q, done_d;

  // The dynamic word is parked in the top of the shadow so the outgoing bit is always the MSB.
  always_comb begin
    state_d = state_q;
    div_d   = div_q;
    bit_d   = bit_q;
    sel_d   = sel_q;
    sh_d    = sh_q;
    case (state_q)
      IDLE: begin
        if (bus.START) begin
          state_d = SHIFT;
          div_d   = '0;
          sel_d   = bus.SEL_STAT;
          if (bus.SEL_STAT) begin
            bit_d = BIT_STAT_TOP;
            sh_d  = bus.STAT_WORD;
          end else begin
            bit_d = BIT_DYN_TOP;
            sh_d  = '0;
            sh_d[SIZESRSTAT-1 -: SIZESRDYN] = bus.DYN_WORD;
          end
        end
      end
      SHIFT: begin
        if (div_q == DIV_LAST) begin
          div_d = '0;
          sh_d  = {sh_q[SIZESRSTAT-2:0], 1'b0};
          if (bit_q == '0) begin
            state_d = LATCH;
          end else begin
            bit_d = bit_q - BIT_ONE;
          end
        end else begin
          div_d = div_q + DIV_ONE;
        end
      end
      LATCH: begin
        if (div_q == DIV_LOW_LAST) begin
          div_d   = '0;
          state_d = FIN;
        end else begin
          div_d = div_q + DIV_ONE;
        end
      end
      FIN:     state_d = IDLE;
      default: state_d = IDLE;
    endcase

    // Outputs are registered from next state so the chain pins never glitch.
    sclk_d  = (state_d == SHIFT) && (div_d >= DIV_HALF);
    sdata_d = (state_d == SHIFT) && sh_d[SIZESRSTAT-1];
    dynl_d  = (state_d == LATCH) && !sel_d;
    statl_d = (state_d == LATCH) && sel_d;
    busy_d  = (state_d == SHIFT) || (state_d == LATCH);
    done_d  = (state_d == FIN);
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q <= IDLE;
      div_q   <= '0;
      bit_q   <= '0;
      sel_q   <= 1'b0;
      sh_q    <= '0;
      sdata_q <= 1'b0;
      sclk_q  <= 1'b0;
      dynl_q  <= 1'b0;
      statl_q <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      div_q   <= div_d;
      bit_q   <= bit_d;
      sel_q   <= sel_d;
      sh_q    <= sh_d;
      sdata_q <= sdata_d;
      sclk_q  <= sclk_d;
      dynl_q  <= dynl_d;
      statl_q <= statl_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
    end
  end

  assign bus.SDATA     = sdata_q;
  assign bus.SCLK      = sclk_q;
  assign bus.DYNLATCH  = dynl_q;
  assign bus.STATLATCH = statl_q;
  assign bus.BUSY      = busy_q;
  assign bus.DONE      = done_q;

`ifdef SHIFTREG_READBACK_EN
  logic [SIZESRSTAT-1:0] cap_q, cap_d;
  logic [SIZESRSTAT-1:0] rb_q, rb_d;

  // SDIN is taken just before SCLK rises; cleared capture leaves unused upper bits zero.
  always_comb begin
    cap_d = cap_q;
    rb_d  = rb_q;
    if (state_q == IDLE && bus.START) begin
      cap_d = '0;
    end else if (state_q == SHIFT && div_q == DIV_LOW_LAST) begin
      cap_d = {cap_q[SIZESRSTAT-2:0], bus.SDIN};
    end
    if (state_q == LATCH && state_d == FIN) begin
      rb_d = cap_q;
    end
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      cap_q <= '0;
      rb_q  <= '0;
    end else begin
      cap_q <= cap_d;
      rb_q  <= rb_d;
    end
  end

  assign bus.RB_DATA = rb_q;
`else
  assign bus.RB_DATA = '0;
`endif

endmodule
